tnn_result_packer: RTL and testbench
====================================

Name: tnn_result_packer

Overview:
- Sits directly downstream of the TNN core (AWSVggWrapper) in the clk_a1 domain. Consumes its 64-bit result beats (four 16-bit lanes).
- Packs beats into 512-bit words with per-image framing, zero padding and an end-of-image marker, then buffers them for the async output FIFO.
- The TNN output cannot be back-pressured, so the block detects overflow and flags it rather than stalling.

Parameters:
BEATS_PER_IMG, 10, number of 64-bit result beats per image (1..1023)
OUT_DEPTH, 4, output buffer depth in 512-bit words (power of 2, >=2)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_vld  in  1  result beat valid; accepted unconditionally
in_bits  in  64  result beat; bits[15:0] = lane 0 … bits[63:48] = lane 3
out_vld  out  1  output word valid
out_rdy  in  1  downstream accepts word
out_bits  out  512  packed word; beat k of word at bits[64k+63:64k]
out_last  out  1  word is final word of an image
almost_full  out  1  buffer occupancy >= OUT_DEPTH-1
overflow  out  1  sticky: a completed word was dropped
img_cnt  out  16  completed images, wraps at 2^16
drop_cnt  out  16  dropped words, saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high, clock only): out_vld=0, out_bits=0, out_last=0, almost_full=0, overflow=0, img_cnt=0, drop_cnt=0.
  - Reset also clears slot index, beat counter, assembly register and buffer.
  - A partial word or image in flight at reset is discarded.
- Assembly:
  - 3-bit slot index (0..7) and beat counter (0..BEATS_PER_IMG-1).
  - On in_vld, in_bits is written into slot[idx] of the assembly register.
  - A word completes on the beat where idx==7 or beat_cnt==BEATS_PER_IMG-1.
- Word completion:
  - Slots above idx are zero.
  - last = (beat_cnt==BEATS_PER_IMG-1).
  - Word is pushed to the buffer the next cycle; idx returns to 0 and the assembly register clears.
- End of image: on the final beat, beat_cnt returns to 0 and img_cnt increments at completion, even if the word is dropped.
- Back-to-back beats: a new beat may arrive the cycle after a completing beat and goes to slot 0 of the next word, with no bubble.
- Output buffer:
  - FIFO of {last, 512-bit data}; out_vld = not empty; head drives out_bits/out_last from registers.
  - Pop on out_vld & out_rdy.
  - out_bits/out_last hold their values while out_vld & !out_rdy.
- Latency: with the buffer empty, a completing beat at cycle N gives out_vld=1 with that word at cycle N+2.
- Full-buffer boundaries:
  - Push when full with a pop in the same cycle: push accepted, occupancy unchanged.
  - Push when full without a pop: word dropped, overflow set until reset, drop_cnt +1 (saturating).
- Simultaneous push and pop on an empty buffer: word stored, out_vld=1 next cycle; no bypass.
- almost_full is registered from occupancy and updates one cycle after push/pop. Upstream uses it to stop launching new images.
- BEATS_PER_IMG=8 gives exactly one unpadded word per image. BEATS_PER_IMG=1 gives every word with slot 0 only and last=1.

Test Plan:
- Reset, then 10 beats 0x0001..0x000A (values in lane 0), out_rdy=1:
  - word0 has slots 0..7 = 1..8, out_last=0.
  - word1 has slots 0..1 = 9,10, slots 2..7 = 0, out_last=1.
  - img_cnt=1.
- Two images back-to-back with continuous in_vld, out_rdy=1 → 4 words, out_last pattern 0,1,0,1; img_cnt=2; overflow=0.
- out_rdy=0, then 3 images (6 words) with OUT_DEPTH=4:
  - first 4 words held; 2 dropped; overflow=1, drop_cnt=2.
  - almost_full=1 from the 3rd stored word on.
  - Then out_rdy=1 → exactly the first 4 words emerge in order.
- Buffer full, out_rdy pulsed for one cycle on the same cycle a word completes → no drop, occupancy stays 4, drop_cnt unchanged.
- Reset asserted after beat 5 of an image, then a fresh full image → no partial word emitted; first output word holds slots 0..7 = beats 1..8 of the new image.
- Hold out_rdy=0 with out_vld=1 for 5 cycles → out_bits/out_last stable, then transfer once on out_rdy=1.

Source files
------------

// File: rtl/tnn_result_packer_if.sv
// Result-beat input and packed-word output bundle for tnn_result_packer.
interface tnn_result_packer_if;
  logic         in_vld;
  logic [63:0]  in_bits;
  logic         out_vld;
  logic         out_rdy;
  logic [511:0] out_bits;
  logic         out_last;

  // Producer/consumer side (TNN core feed plus output-FIFO consumer).
  modport master (
    output in_vld,
    output in_bits,
    output out_rdy,
    input  out_vld,
    input  out_bits,
    input  out_last
  );

  // Packer side.
  modport slave (
    input  in_vld,
    input  in_bits,
    input  out_rdy,
    output out_vld,
    output out_bits,
    output out_last
  );
endinterface

// File: rtl/tnn_result_packer.sv
// Packs 64-bit TNN result beats into 512-bit words with per-image framing.
// The TNN core cannot be stalled, so completed words that find the output
// buffer full are dropped and counted instead of back-pressuring.
module tnn_result_packer #(
  parameter int unsigned BEATS_PER_IMG = 10,
  parameter int unsigned OUT_DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  tnn_result_packer_if.slave bus,
  output logic        almost_full,
  output logic        overflow,
  output logic [15:0] img_cnt,
  output logic [15:0] drop_cnt
);

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned SLOTS  = 8;
  localparam int unsigned WORD_W = BEAT_W * SLOTS;
  localparam int unsigned ENTRY_W = WORD_W + 1;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_IMG - 1);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(OUT_DEPTH);
  localparam logic [OCC_W-1:0] AF_OCC    = OCC_W'(OUT_DEPTH - 1);

  // Assembly state
  logic [IDX_W-1:0]              idx_q;
  logic [CNT_W-1:0]              beat_q;
  logic [SLOTS-1:0][BEAT_W-1:0]  asm_q;
  logic                          push_vld_q;
  logic                          push_last_q;
  logic [WORD_W-1:0]             push_data_q;

  // Output buffer state
  logic [ENTRY_W-1:0]            mem [OUT_DEPTH];
  logic [PTR_W-1:0]              wr_q;
  logic [PTR_W-1:0]              rd_q;
  logic [OCC_W-1:0]              occ_q;
  logic                          out_vld_q;
  logic [ENTRY_W-1:0]            head_q;

  // Combinational next values
  logic [SLOTS-1:0][BEAT_W-1:0]  fill;
  logic                          end_img;
  logic                          word_done;
  logic                          pop;
  logic                          full;
  logic                          push_acc;
  logic                          drop;
  logic [OCC_W-1:0]              occ_nxt;
  logic [PTR_W-1:0]              wr_nxt;
  logic [PTR_W-1:0]              rd_nxt;
  logic [ENTRY_W-1:0]            head_nxt;

  // Merge the incoming beat into the current slot and detect word completion.
  // Slots above idx are already zero because the register clears per word.
  always_comb begin
    fill           = asm_q;
    fill[idx_q]    = bus.in_bits;
    end_img        = (beat_q == LAST_BEAT);
    word_done      = bus.in_vld && ((idx_q == LAST_SLOT) || end_img);
  end

  // Slot/beat counters, assembly register and the one-cycle push stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q       <= '0;
      beat_q      <= '0;
      asm_q       <= '0;
      push_vld_q  <= 1'b0;
      push_last_q <= 1'b0;
      push_data_q <= '0;
      img_cnt     <= '0;
    end else begin
      push_vld_q <= word_done;
      if (bus.in_vld) begin
        if (word_done) begin
          push_data_q <= fill;
          push_last_q <= end_img;
          asm_q       <= '0;
          idx_q       <= '0;
        end else begin
          asm_q <= fill;
          idx_q <= idx_q + IDX_W'(1);
        end
        if (end_img) begin
          beat_q  <= '0;
          img_cnt <= img_cnt + 16'd1;
        end else begin
          beat_q <= beat_q + CNT_W'(1);
        end
      end
    end
  end

  // Buffer control: push accepted when not full or when the head leaves
  // in the same cycle; otherwise the word is dropped.
  always_comb begin
    pop      = out_vld_q && bus.out_rdy;
    full     = (occ_q == FULL_OCC);
    push_acc = push_vld_q && (!full || pop);
    drop     = push_vld_q && full && !pop;
    occ_nxt  = occ_q;
    wr_nxt   = wr_q;
    rd_nxt   = rd_q;
    if (push_acc && !pop) begin
      occ_nxt = occ_q + OCC_W'(1);
    end else if (!push_acc && pop) begin
      occ_nxt = occ_q - OCC_W'(1);
    end
    if (push_acc) begin
      wr_nxt = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_nxt = rd_q + PTR_W'(1);
    end
    // New head is the incoming word when it lands in the slot the read
    // pointer moves to, otherwise whatever is stored there.
    if (occ_nxt == '0) begin
      head_nxt = '0;
    end else if (push_acc && (rd_nxt == wr_q)) begin
      head_nxt = {push_last_q, push_data_q};
    end else begin
      head_nxt = mem[rd_nxt];
    end
  end

  // Buffer storage, pointers, registered head and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_q        <= '0;
      rd_q        <= '0;
      occ_q       <= '0;
      out_vld_q   <= 1'b0;
      head_q      <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (push_acc) begin
        mem[wr_q] <= {push_last_q, push_data_q};
      end
      wr_q        <= wr_nxt;
      rd_q        <= rd_nxt;
      occ_q       <= occ_nxt;
      out_vld_q   <= (occ_nxt != '0);
      head_q      <= head_nxt;
      almost_full <= (occ_nxt >= AF_OCC);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.out_bits = head_q[WORD_W-1:0];
  assign bus.out_last = head_q[WORD_W];

endmodule

// File: tb/tb_tnn_result_packer.sv
// Directed bench for tnn_result_packer (BEATS_PER_IMG=10, OUT_DEPTH=4).
module tb_tnn_result_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        almost_full;
  logic        overflow;
  logic [15:0] img_cnt;
  logic [15:0] drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [512:0] got_q [$];

  tnn_result_packer_if bus ();

  tnn_result_packer #(
    .BEATS_PER_IMG (10),
    .OUT_DEPTH     (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .almost_full (almost_full),
    .overflow    (overflow),
    .img_cnt     (img_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clock = ~clock;

  // Capture every transferred word; handshake is stable around the falling edge.
  always @(negedge clock) begin
    if (!reset && bus.out_vld && bus.out_rdy) begin
      got_q.push_back({bus.out_last, bus.out_bits});
    end
  end

  task automatic check(input string tag, input logic [512:0] got, input logic [512:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word with consecutive values base.. in lane 0 of the first n slots.
  function automatic logic [511:0] mk_word(input int base, input int n);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      w[64*k +: 64] = 64'(base + k);
    end
    return w;
  endfunction

  task automatic beat(input int v);
    @(posedge clock);
    #1;
    bus.in_vld  = 1'b1;
    bus.in_bits = 64'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      bus.in_vld  = 1'b0;
      bus.in_bits = '0;
    end
  endtask

  task automatic image(input int base);
    for (int k = 0; k < 10; k++) begin
      beat(base + k);
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset      = 1'b1;
    bus.in_vld = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic expect_word(input string tag, input int base, input int n, input logic last);
    logic [512:0] w;
    check({tag, "_present"}, 513'(got_q.size() != 0), 513'(1));
    if (got_q.size() != 0) begin
      w = got_q.pop_front();
      check(tag, w, {last, mk_word(base, n)});
    end
  endtask

  task automatic expect_empty(input string tag);
    check(tag, 513'(got_q.size()), 513'(0));
  endtask

  initial begin
    reset       = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_bits = '0;
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_out_vld",  513'(bus.out_vld),  513'(0));
    check("rst_out_bits", 513'(bus.out_bits), 513'(0));
    check("rst_out_last", 513'(bus.out_last), 513'(0));
    check("rst_af",       513'(almost_full),  513'(0));
    check("rst_ovf",      513'(overflow),     513'(0));
    check("rst_img_cnt",  513'(img_cnt),      513'(0));
    check("rst_drop_cnt", 513'(drop_cnt),     513'(0));

    // One image, including completion-to-valid latency of two cycles
    bus.out_rdy = 1'b1;
    for (int v = 1; v <= 8; v++) beat(v);
    idle(1);
    @(negedge clock);
    check("lat_n1_vld", 513'(bus.out_vld), 513'(0));
    @(negedge clock);
    check("lat_n2_vld",  513'(bus.out_vld),  513'(1));
    check("lat_n2_bits", 513'(bus.out_bits), 513'(mk_word(1, 8)));
    check("lat_n2_last", 513'(bus.out_last), 513'(0));
    beat(9);
    beat(10);
    idle(4);
    expect_word("img1_w0", 1, 8, 1'b0);
    expect_word("img1_w1", 9, 2, 1'b1);
    expect_empty("img1_empty");
    check("img1_img_cnt", 513'(img_cnt), 513'(1));

    // Two back-to-back images
    do_reset();
    image(1);
    image(11);
    idle(4);
    expect_word("b2b_w0", 1, 8, 1'b0);
    expect_word("b2b_w1", 9, 2, 1'b1);
    expect_word("b2b_w2", 11, 8, 1'b0);
    expect_word("b2b_w3", 19, 2, 1'b1);
    expect_empty("b2b_empty");
    check("b2b_img_cnt", 513'(img_cnt),  513'(2));
    check("b2b_ovf",     513'(overflow), 513'(0));

    // Overflow: three images into a 4-deep buffer with no draining
    do_reset();
    bus.out_rdy = 1'b0;
    image(1);
    idle(3);
    check("ovf_af_occ2", 513'(almost_full), 513'(0));
    for (int v = 11; v <= 18; v++) beat(v);
    idle(3);
    check("ovf_af_occ3", 513'(almost_full), 513'(1));
    beat(19);
    beat(20);
    image(21);
    idle(3);
    check("ovf_flag",     513'(overflow),     513'(1));
    check("ovf_drop_cnt", 513'(drop_cnt),     513'(2));
    check("ovf_img_cnt",  513'(img_cnt),      513'(3));
    check("ovf_af_full",  513'(almost_full),  513'(1));
    check("ovf_head",     513'(bus.out_bits), 513'(mk_word(1, 8)));
    @(posedge clock);
    #1;
    bus.out_rdy = 1'b1;
    idle(8);
    expect_word("ovf_w0", 1, 8, 1'b0);
    expect_word("ovf_w1", 9, 2, 1'b1);
    expect_word("ovf_w2", 11, 8, 1'b0);
    expect_word("ovf_w3", 19, 2, 1'b1);
    expect_empty("ovf_empty");
    check("ovf_drain_vld", 513'(bus.out_vld), 513'(0));
    check("ovf_drain_af",  513'(almost_full), 513'(0));
    check("ovf_sticky",    513'(overflow),    513'(1));

    // Full buffer, single-cycle pop exactly when the new word is pushed
    do_reset();
    bus.out_rdy = 1'b0;
    image(1);
    image(11);
    idle(3);
    check("fp_af_full", 513'(almost_full), 513'(1));
    for (int v = 21; v <= 28; v++) beat(v);
    @(posedge clock);
    #1;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    @(posedge clock);
    #1;
    bus.out_rdy = 1'b0;
    idle(3);
    check("fp_drop_cnt", 513'(drop_cnt),     513'(0));
    check("fp_ovf",      513'(overflow),     513'(0));
    check("fp_af",       513'(almost_full),  513'(1));
    check("fp_head",     513'(bus.out_bits), 513'(mk_word(9, 2)));
    check("fp_head_last", 513'(bus.out_last), 513'(1));
    bus.out_rdy = 1'b1;
    idle(8);
    expect_word("fp_w0", 1, 8, 1'b0);
    expect_word("fp_w1", 9, 2, 1'b1);
    expect_word("fp_w2", 11, 8, 1'b0);
    expect_word("fp_w3", 19, 2, 1'b1);
    expect_word("fp_w4", 21, 8, 1'b0);
    expect_empty("fp_empty");

    // Reset in the middle of an image discards the partial word
    do_reset();
    bus.out_rdy = 1'b1;
    for (int v = 81; v <= 85; v++) beat(v);
    do_reset();
    image(1);
    idle(4);
    expect_word("mid_w0", 1, 8, 1'b0);
    expect_word("mid_w1", 9, 2, 1'b1);
    expect_empty("mid_empty");
    check("mid_img_cnt", 513'(img_cnt), 513'(1));

    // Head holds while stalled, then transfers exactly once
    do_reset();
    bus.out_rdy = 1'b0;
    image(1);
    idle(3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check($sformatf("hold%0d_vld", c),  513'(bus.out_vld),  513'(1));
      check($sformatf("hold%0d_bits", c), 513'(bus.out_bits), 513'(mk_word(1, 8)));
      check($sformatf("hold%0d_last", c), 513'(bus.out_last), 513'(0));
    end
    @(posedge clock);
    #1;
    bus.out_rdy = 1'b1;
    @(posedge clock);
    #1;
    bus.out_rdy = 1'b0;
    idle(2);
    expect_word("hold_xfer", 1, 8, 1'b0);
    expect_empty("hold_once");
    check("hold_next_vld",  513'(bus.out_vld),  513'(1));
    check("hold_next_bits", 513'(bus.out_bits), 513'(mk_word(9, 2)));
    check("hold_next_last", 513'(bus.out_last), 513'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
